// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared FSM state encoding and default geometry constants for
//               the data memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_DEPTH       = 4096;
  localparam int DEF_WAIT_CYCLES = 1;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/data_memory_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl_if
// Description : Request/response bus between a requester (master) and the
//               data memory controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  ready, done, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, done, rdata, err, busy
  );

endinterface : data_memory_ctrl_if
`default_nettype wire

// File: rtl/data_memory_ctrl_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Single-port storage; synchronous write, combinational read,
//               contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Commit a write on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule : mem_array
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl
// Description : Request/response controller in front of a single-port word
//               memory with programmable access latency and range checking.
//               Define MEM_INIT_CLEAR_EN to zero the whole array after reset
//               (busy is high during that sweep).
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_ctrl_if.slave bus
);

  localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      c_wait  = 4'(WAIT_CYCLES);
`ifdef MEM_INIT_CLEAR_EN
  localparam logic [c_idx_w-1:0] c_last     = (c_idx_w)'(DEPTH - 1);
  localparam logic               c_busy_rst = 1'b1;
`else
  localparam logic               c_busy_rst = 1'b0;
`endif

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ready;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;
`ifdef MEM_INIT_CLEAR_EN
  logic [c_idx_w-1:0]  r_init_addr;
`endif

  logic                w_accept;
  logic                w_cur_we;
  logic [ADDR_W-1:0]   w_cur_addr;
  logic [DATA_W-1:0]   w_cur_wdata;
  logic                w_in_range;
  logic                w_enter_resp;
  logic                w_mem_we;
  logic [c_idx_w-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;
  logic [DATA_W-1:0]  w_mem_rdata;

  // The "current" request is the bus itself on the accept edge (needed when
  // there is no wait phase) and the captured copy afterwards.
  always_comb begin
    w_accept     = (r_state == ST_IDLE) && bus.req;
    w_cur_we     = w_accept ? bus.we    : r_we;
    w_cur_addr   = w_accept ? bus.addr  : r_addr;
    w_cur_wdata  = w_accept ? bus.wdata : r_wdata;
    w_in_range   = ({1'b0, w_cur_addr} < c_depth);
    w_enter_resp = (w_accept && (c_wait == 4'd0)) ||
                   ((r_state == ST_WAIT) && (r_cnt == 4'd1));
    w_mem_we     = w_enter_resp && w_cur_we && w_in_range;
    w_mem_addr   = w_cur_addr[c_idx_w-1:0];
    w_mem_wdata  = w_cur_wdata;
`ifdef MEM_INIT_CLEAR_EN
    if (r_state == ST_INIT) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_init_addr;
      w_mem_wdata = '0;
    end
`endif
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (c_idx_w)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .addr  (w_mem_addr),
    .wdata (w_mem_wdata),
    .rdata (w_mem_rdata)
  );

`ifdef MEM_INIT_CLEAR_EN
  // Sweep address for the post-reset clear, one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_addr <= r_init_addr + 1'b1;
    end
  end
`endif

  // Main FSM with request capture and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_busy  <= c_busy_rst;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
      case (r_state)
        ST_INIT: begin
`ifdef MEM_INIT_CLEAR_EN
          if (r_init_addr == c_last) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
`else
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
`endif
        end
        ST_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= c_wait;
            r_state <= ST_WAIT;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
      // Entering RESP overrides the per-state next state; reads latch rdata
      // here, writes leave the previous read value in place.
      if (w_enter_resp) begin
        r_state <= ST_RESP;
        r_done  <= 1'b1;
        r_err   <= !w_in_range;
        if (!w_cur_we) begin
          r_rdata <= w_in_range ? w_mem_rdata : '0;
        end
      end
    end
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;
  assign bus.busy  = r_busy;

endmodule : data_memory_ctrl
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_ctrl
// Description : Directed self-checking bench. DUT "a" uses default geometry
//               (WAIT_CYCLES=1, DEPTH=4096); DUT "b" uses WAIT_CYCLES=0,
//               DEPTH=16. Honours MEM_INIT_CLEAR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

`ifdef MEM_INIT_CLEAR_EN
  localparam int   c_init_a   = 4096;
  localparam int   c_init_b   = 16;
  localparam logic c_busy_exp = 1'b1;
`else
  localparam int   c_init_a   = 1;
  localparam int   c_init_b   = 1;
  localparam logic c_busy_exp = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  data_memory_ctrl_if #(.DATA_W(12), .ADDR_W(12)) ba ();
  data_memory_ctrl_if #(.DATA_W(12), .ADDR_W(12)) bb ();

  data_memory_ctrl #(
    .DATA_W(12), .ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  data_memory_ctrl #(
    .DATA_W(12), .ADDR_W(12), .DEPTH(16), .WAIT_CYCLES(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on bus a; lat = edges after the accept edge until done.
  task automatic xact_a(input logic w, input logic [11:0] ad, input logic [11:0] wd,
                        output logic [11:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    while (!ba.ready && guard < 9000) begin @(posedge clk); #1; guard++; end
    ba.req = 1'b1; ba.we = w; ba.addr = ad; ba.wdata = wd;
    @(posedge clk); #1;
    ba.req = 1'b0;
    lat = 0;
    while (!ba.done && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = ba.rdata; er = ba.err;
  endtask

  task automatic xact_b(input logic w, input logic [11:0] ad, input logic [11:0] wd,
                        output logic [11:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    while (!bb.ready && guard < 9000) begin @(posedge clk); #1; guard++; end
    bb.req = 1'b1; bb.we = w; bb.addr = ad; bb.wdata = wd;
    if (bb.done) begin end
    @(posedge clk); #1;
    bb.req = 1'b0;
    lat = 0;
    while (!bb.done && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = bb.rdata; er = bb.err;
  endtask

  task automatic test_reset();
    int n, na, nb;
    rst = 1'b1;
    #3;
    checks++; if (ba.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ba.ready); end
    checks++; if (ba.done !== 1'b0 || ba.err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", ba.done, ba.err); end
    checks++; if (ba.rdata !== 12'h000) begin failures++; $display("FAIL reset_rdata got=%h exp=000", ba.rdata); end
    checks++; if (ba.busy !== c_busy_exp) begin failures++; $display("FAIL reset_busy got=%b exp=%b", ba.busy, c_busy_exp); end
    @(posedge clk); #1;
    rst = 1'b0;
    na = -1; nb = -1; n = 0;
    while ((na < 0 || nb < 0) && n < 9000) begin
      @(posedge clk); #1; n++;
      if (na < 0 && ba.ready) na = n;
      if (nb < 0 && bb.ready) nb = n;
    end
    checks++; if (na != c_init_a) begin failures++; $display("FAIL init_len_a got=%0d exp=%0d", na, c_init_a); end
    checks++; if (nb != c_init_b) begin failures++; $display("FAIL init_len_b got=%0d exp=%0d", nb, c_init_b); end
    checks++; if (ba.busy !== 1'b0) begin failures++; $display("FAIL busy_after_init got=%b exp=0", ba.busy); end
  endtask

  task automatic test_read_cleared();
`ifdef MEM_INIT_CLEAR_EN
    logic [11:0] rd; logic er; int lat;
    xact_a(1'b0, 12'd7, 12'h000, rd, er, lat);
    checks++; if (rd !== 12'h000 || lat != 1) begin failures++; $display("FAIL read_cleared got=%h/%0d exp=000/1", rd, lat); end
`endif
  endtask

  task automatic test_write_read();
    logic [11:0] rd; logic er; int lat;
    xact_a(1'b1, 12'd100, 12'hABC, rd, er, lat);
    checks++; if (lat != 1 || er !== 1'b0) begin failures++; $display("FAIL wr100 got lat=%0d err=%b exp lat=1 err=0", lat, er); end
    xact_a(1'b0, 12'd100, 12'h000, rd, er, lat);
    checks++; if (rd !== 12'hABC || er !== 1'b0 || lat != 1) begin failures++; $display("FAIL rd100 got=%h/%b/%0d exp=abc/0/1", rd, er, lat); end
    xact_a(1'b1, 12'd0, 12'h555, rd, er, lat);
    xact_a(1'b1, 12'd4095, 12'hAAA, rd, er, lat);
    checks++; if (rd !== 12'hABC || er !== 1'b0) begin failures++; $display("FAIL rdata_hold_after_wr got=%h/%b exp=abc/0", rd, er); end
    xact_a(1'b0, 12'd4095, 12'h000, rd, er, lat);
    checks++; if (rd !== 12'hAAA || er !== 1'b0) begin failures++; $display("FAIL rd4095 got=%h/%b exp=aaa/0", rd, er); end
    xact_a(1'b0, 12'd0, 12'h000, rd, er, lat);
    checks++; if (rd !== 12'h555) begin failures++; $display("FAIL rd0 got=%h exp=555", rd); end
    @(posedge clk); #1;
    checks++; if (ba.done !== 1'b0 || ba.rdata !== 12'h555) begin failures++; $display("FAIL post_resp got done=%b rdata=%h exp 0/555", ba.done, ba.rdata); end
  endtask

  task automatic test_ready_low();
    int low_a, low_b, n;
    while (!ba.ready || !bb.ready) begin @(posedge clk); #1; end
    ba.req = 1'b1; ba.we = 1'b0; ba.addr = 12'd100;
    bb.req = 1'b1; bb.we = 1'b0; bb.addr = 12'd3;
    @(posedge clk); #1;
    ba.req = 1'b0; bb.req = 1'b0;
    low_a = 0; low_b = 0; n = 0;
    while ((!ba.ready || !bb.ready) && n < 20) begin
      if (!ba.ready) low_a++;
      if (!bb.ready) low_b++;
      @(posedge clk); #1; n++;
    end
    checks++; if (low_a != 2) begin failures++; $display("FAIL ready_low_a got=%0d exp=2", low_a); end
    checks++; if (low_b != 1) begin failures++; $display("FAIL ready_low_b got=%0d exp=1", low_b); end
  endtask

  task automatic test_out_of_range();
    logic [11:0] rd; logic er; int lat;
    for (int i = 0; i < 16; i++) xact_b(1'b1, 12'(i), 12'(i * 17 + 3), rd, er, lat);
    xact_b(1'b0, 12'd15, 12'h000, rd, er, lat);
    checks++; if (rd !== 12'd258 || er !== 1'b0 || lat != 0) begin failures++; $display("FAIL b_rd15 got=%h/%b/%0d exp=102/0/0", rd, er, lat); end
    xact_b(1'b0, 12'd20, 12'h000, rd, er, lat);
    checks++; if (rd !== 12'h000 || er !== 1'b1 || lat != 0) begin failures++; $display("FAIL b_rd20 got=%h/%b/%0d exp=000/1/0", rd, er, lat); end
    xact_b(1'b0, 12'd16, 12'h000, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL b_rd16_err got=%b exp=1", er); end
    xact_b(1'b1, 12'd20, 12'hFFF, rd, er, lat);
    checks++; if (er !== 1'b1 || lat != 0) begin failures++; $display("FAIL b_wr20 got err=%b lat=%0d exp 1/0", er, lat); end
    @(posedge clk); #1;
    checks++; if (bb.err !== 1'b0) begin failures++; $display("FAIL b_err_after_resp got=%b exp=0", bb.err); end
    for (int i = 0; i < 16; i++) begin
      xact_b(1'b0, 12'(i), 12'h000, rd, er, lat);
      checks++;
      if (rd !== 12'(i * 17 + 3) || er !== 1'b0) begin
        failures++; $display("FAIL b_keep[%0d] got=%h/%b exp=%h/0", i, rd, er, 12'(i * 17 + 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] rd; logic er; int lat;
    int acc, dones, cyc;
    logic rdy_now;
    acc = 0; dones = 0; cyc = 0;
    while (!ba.ready) begin @(posedge clk); #1; end
    ba.req = 1'b1; ba.we = 1'b1; ba.addr = 12'd200; ba.wdata = 12'h111;
    while (cyc < 20) begin
      rdy_now = ba.ready;
      @(posedge clk); #1; cyc++;
      if (ba.done) dones++;
      if (rdy_now && ba.req) begin
        acc++;
        if (acc == 3) ba.req = 1'b0;
        else begin ba.addr = 12'(200 + acc); ba.wdata = 12'(12'h111 * (acc + 1)); end
      end
    end
    checks++; if (dones != 3) begin failures++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
    for (int i = 0; i < 3; i++) begin
      xact_a(1'b0, 12'(200 + i), 12'h000, rd, er, lat);
      checks++;
      if (rd !== 12'(12'h111 * (i + 1))) begin
        failures++; $display("FAIL b2b_rd[%0d] got=%h exp=%h", i, rd, 12'(12'h111 * (i + 1)));
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic [11:0] rd; logic er; int lat, n, seen;
    logic [11:0] exp5;
    xact_a(1'b1, 12'd5, 12'h123, rd, er, lat);
    xact_a(1'b0, 12'd5, 12'h000, rd, er, lat);
    while (!ba.ready) begin @(posedge clk); #1; end
    ba.req = 1'b1; ba.we = 1'b1; ba.addr = 12'd5; ba.wdata = 12'h456;
    @(posedge clk); #1;
    ba.req = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (ba.done !== 1'b0 || ba.ready !== 1'b0 || ba.rdata !== 12'h000) begin
      failures++; $display("FAIL async_reset got done=%b ready=%b rdata=%h exp 0/0/000", ba.done, ba.ready, ba.rdata);
    end
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (ba.done) seen++; end
    rst = 1'b0;
    n = 0;
    while (!ba.ready && n < 9000) begin @(posedge clk); #1; n++; if (ba.done) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL reset_no_done got=%0d exp=0", seen); end
`ifdef MEM_INIT_CLEAR_EN
    exp5 = 12'h000;
`else
    exp5 = 12'h123;
`endif
    xact_a(1'b0, 12'd5, 12'h000, rd, er, lat);
    checks++; if (rd !== exp5) begin failures++; $display("FAIL reset_no_commit got=%h exp=%h", rd, exp5); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    ba.req = 1'b0; ba.we = 1'b0; ba.addr = '0; ba.wdata = '0;
    bb.req = 1'b0; bb.we = 1'b0; bb.addr = '0; bb.wdata = '0;
    test_reset();
    test_read_cleared();
    test_write_read();
    test_ready_low();
    test_out_of_range();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_data_memory_ctrl
`default_nettype wire
